inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Inverse of the control decoder: accepts decoded RV32I instruction fields over a valid/ready stream and packs them into 32-bit instruction words.
- Writes each word into instruction memory through a single write port at consecutive word addresses.
- Used by the testbench and boot loader to build program images in instruction memory without precompiled hex files.

Parameters:
- CNT_W, 16, width of the instruction counter output.
- NOP_WORD, 32'h00000013, word substituted for illegal requests when the legality check is compiled in.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle pulse that begins a program load.
- base_addr  input  32  byte address of the first word; sampled on start.
- in_valid  input  1  request-field bundle is valid.
- in_ready  output  1  encoder accepts the bundle this cycle.
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are reserved.
- in_opcode  input  7  opcode[6:0].
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7.
- in_imm  input  32  immediate value (unshifted; for U-type, bits [31:12] are used).
- in_last  input  1  marks the final instruction of the load.
- im_we  output  1  instruction-memory write enable.
- im_addr  output  32  instruction-memory byte address.
- im_wdata  output  32  encoded instruction word.
- busy  output  1  load in progress.
- done  output  1  single-cycle pulse at load completion.
- count  output  CNT_W  words written in the current load.
- err  output  1  sticky illegal-request flag.

Behaviour:
- Reset state: all outputs 0 (in_ready, im_we, im_addr, im_wdata, busy, done, count, err); FSM=IDLE. Reset asserted mid-load aborts it immediately; no further write occurs.
- IDLE:
  - in_ready=0, busy=0.
  - start=1: addr<=base_addr, count<=0, err<=0, go to ENC.
- ENC:
  - busy=1, in_ready=1.
  - On in_valid&in_ready: encoded word -> word_reg, in_last -> last_reg, go to WR. Otherwise stay in ENC.
- WR:
  - in_ready=0, im_we=1 for exactly one cycle, im_addr=addr, im_wdata=word_reg.
  - Next edge: addr<=addr+4 (wraps modulo 2^32); count<=count+1, saturating at all ones.
  - last_reg=1: go to DONE; otherwise go to ENC.
- DONE:
  - done=1 for one cycle, busy=1; then go to IDLE.
  - count and err hold until the next start.
- Throughput and latency:
  - One instruction per 2 cycles.
  - Accept edge to im_we high: 1 cycle.
  - Last write to done pulse: 1 cycle.
- start while busy is ignored.
- im_addr and im_wdata hold their last values when im_we=0.
- Encoding, op=in_opcode, imm=in_imm:
  - R: {funct7, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - Reserved fmt: word 32'h0.
- Unused immediate bits are ignored. B/J imm[0] is dropped without error.

Optional Feature:
- Macro: INST_ENC_LEGAL_CHECK_EN.
- Defined:
  - Each accepted request is checked for an opcode/format pair that is one of: 0110011/R, 0000011/I, 0010011/I, 1100111/I, 0100011/S, 1100011/B, 0010111/U, 0110111/U, 1101111/J.
  - A mismatch or reserved fmt writes NOP_WORD in place of the encoded word and sets err, which stays set until the next start.
  - The write still occurs and count still increments.
- Not defined: no check, err tied to 0, encoding exactly as above.

Test Plan:
- start, base 0x0; R op=0110011 rd=3 rs1=1 rs2=2 f3=0 f7=0 last=1 -> im_we at addr 0x0, data 0x002081B3; done 1 cycle later; count=1.
- I op=0010011 rd=5 rs1=0 f3=0 imm=0xFFFFFFFF -> data 0xFFF00293.
- S op=0100011 f3=2 rs1=1 rs2=2 imm=8 -> data 0x0020A423.
- J op=1101111 rd=1 imm=8 -> data 0x008000EF.
- Three-instruction sequence:
  - Stimulus: base 0x100, in_valid held high, last on the third request.
  - Required: writes at 0x100, 0x104 and 0x108 on alternate cycles; done pulse; count=3.
  - A start issued mid-load is ignored.
  - A rst pulse during WR suppresses that write, and all outputs return to 0.
- With INST_ENC_LEGAL_CHECK_EN: fmt=R with op=0000011 -> data 0x00000013, err=1 sticky until the next start. Without the macro: data is the raw R-packing and err=0.

Source files
------------

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: valid/ready stream of decoded RV32I instruction fields
// master drives the request fields and in_valid; slave returns in_ready.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
        output in_funct3, in_funct7, in_imm, in_last,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
        input  in_funct3, in_funct7, in_imm, in_last,
        output in_ready
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into words and writes them to consecutive instruction-memory addresses
// Ports: clk, rst (async, active-high); start/base_addr begin a load at a byte address;
// req (inst_encoder_if.slave) carries the field stream; im_we/im_addr/im_wdata form the
// memory write port; busy, done (1-cycle pulse), count (words written) and err (sticky) report status.
// Optional macro INST_ENC_LEGAL_CHECK_EN: illegal opcode/format pairs are written as NOP_WORD and set err.
module inst_encoder #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    inst_encoder_if.slave    req,
    output logic             im_we,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, ENC, WR, DONE} state_t;
    state_t             r_state, w_next;
    logic [31:0]        r_addr, r_im_addr, r_im_wdata, w_raw, w_word;
    logic [CNT_W-1:0]   r_count;
    logic               r_last, w_acc, w_bad, w_start;
    assign w_acc   = r_state == ENC && req.in_valid;
    assign w_start = r_state == IDLE && start;
    always_comb begin
        w_next = r_state == IDLE ? (start ? ENC : IDLE) :
                 r_state == ENC  ? (req.in_valid ? WR : ENC) :
                 r_state == WR   ? (r_last ? DONE : ENC) : IDLE;
        req.in_ready = r_state == ENC;
        im_we        = r_state == WR;
        busy         = r_state != IDLE;
        done         = r_state == DONE;
    end
    always_comb begin
        w_raw = 32'h0;
        case (req.in_fmt)
            3'd0: w_raw = {req.in_funct7, req.in_rs2, req.in_rs1, req.in_funct3, req.in_rd, req.in_opcode};
            3'd1: w_raw = {req.in_imm[11:0], req.in_rs1, req.in_funct3, req.in_rd, req.in_opcode};
            3'd2: w_raw = {req.in_imm[11:5], req.in_rs2, req.in_rs1, req.in_funct3, req.in_imm[4:0], req.in_opcode};
            3'd3: w_raw = {req.in_imm[12], req.in_imm[10:5], req.in_rs2, req.in_rs1, req.in_funct3,
                           req.in_imm[4:1], req.in_imm[11], req.in_opcode};
            3'd4: w_raw = {req.in_imm[31:12], req.in_rd, req.in_opcode};
            3'd5: w_raw = {req.in_imm[20], req.in_imm[10:1], req.in_imm[11], req.in_imm[19:12],
                           req.in_rd, req.in_opcode};
            default: w_raw = 32'h0;
        endcase
        w_word = w_bad ? NOP_WORD : w_raw;
    end
`ifdef INST_ENC_LEGAL_CHECK_EN
    logic r_err;
    assign w_bad = !((req.in_fmt == 3'd0 && req.in_opcode == 7'b0110011) ||
                     (req.in_fmt == 3'd1 && (req.in_opcode == 7'b0000011 ||
                                             req.in_opcode == 7'b0010011 ||
                                             req.in_opcode == 7'b1100111)) ||
                     (req.in_fmt == 3'd2 && req.in_opcode == 7'b0100011) ||
                     (req.in_fmt == 3'd3 && req.in_opcode == 7'b1100011) ||
                     (req.in_fmt == 3'd4 && (req.in_opcode == 7'b0010111 ||
                                             req.in_opcode == 7'b0110111)) ||
                     (req.in_fmt == 3'd5 && req.in_opcode == 7'b1101111));
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_err <= 1'b0;
        else if (w_start)
            r_err <= 1'b0;
        else if (w_acc && w_bad)
            r_err <= 1'b1;
    assign err = r_err;
`else
    assign w_bad = 1'b0;
    assign err   = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    // Output address/data registers are loaded on accept so they hold between writes.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_last     <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= base_addr;
                r_count <= '0;
            end
            if (w_acc) begin
                r_im_addr  <= r_addr;
                r_im_wdata <= w_word;
                r_last     <= req.in_last;
            end
            if (r_state == WR) begin
                r_addr  <= r_addr + 32'd4;
                r_count <= r_count + CNT_W'(r_count != '1);
            end
        end
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign count    = r_count;
endmodule
